// File: rtl/mod_pkg.sv
// Shared types and constants for the sequential modular reducer.
//   state_e       : controller states (IDLE / RUN / HOLD)
//   DEFAULT_MOD_C : reset modulus, 2^256 - 2^32 - 977
//   calc_n()      : cycles per operand, ceil(in_w / r)
package mod_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic [255:0] DEFAULT_MOD_C =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  function automatic int unsigned calc_n(input int unsigned in_w, input int unsigned r);
    return (in_w + r - 1) / r;
  endfunction

endpackage

// File: rtl/mod_step.sv
// One restoring-division step: shift in one operand bit, conditionally subtract m.
//   rem_i  : partial remainder (M_W+1 bits, < m on entry when m != 0)
//   bit_i  : next operand bit, MSB first
//   m_i    : modulus
//   rem_c  : updated partial remainder
//   qbit_c : quotient bit produced by this step
module mod_step import mod_pkg::*; #(
  parameter int unsigned M_W = 256
) (
  input  logic [M_W:0]   rem_i,
  input  logic           bit_i,
  input  logic [M_W-1:0] m_i,
  output logic [M_W:0]   rem_c,
  output logic           qbit_c
);

  logic [M_W+1:0] shifted;
  logic [M_W+1:0] m_ext;

  // Widened by one bit so a zero modulus (unbounded remainder) cannot wrap the compare.
  always_comb begin
    shifted = {rem_i, bit_i};
    m_ext   = (M_W+2)'(m_i);
    qbit_c  = (shifted >= m_ext);
    rem_c   = qbit_c ? (M_W+1)'(shifted - m_ext) : (M_W+1)'(shifted);
  end

endmodule

// File: rtl/mod_reduce_seq.sv
// Sequential modular reducer: o = x mod m, R operand bits retired per clock.
// Optional feature macro: MODRED_QUOT_EN adds the quot port and quotient register.
//   clk, reset          : clock, asynchronous active-high reset
//   m_valid/m_data      : modulus load (accepted while m_ready)
//   in_valid/x          : operand (accepted while in_ready)
//   out_valid/out_ready : result handshake, o = remainder, err = zero modulus
//   quot                : floor(x/m), all ones when m == 0 (MODRED_QUOT_EN only)
module mod_reduce_seq import mod_pkg::*; #(
  parameter int unsigned   IN_W        = 300,
  parameter int unsigned   M_W         = 256,
  parameter int unsigned   R           = 4,
  parameter logic [M_W-1:0] DEFAULT_MOD = M_W'(DEFAULT_MOD_C)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            m_valid,
  input  logic [M_W-1:0]  m_data,
  output logic            m_ready,
  input  logic            in_valid,
  input  logic [IN_W-1:0] x,
  output logic            in_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [M_W-1:0]  o,
  output logic            err
`ifdef MODRED_QUOT_EN
  ,
  output logic [IN_W-1:0] quot
`endif
);

  localparam int unsigned N     = calc_n(IN_W, R);
  localparam int unsigned NR    = N * R;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  state_e           state_q, state_d;
  logic [NR-1:0]    sh_q, sh_d;
  logic [M_W:0]     rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [M_W-1:0]   mod_q, mod_d;
  logic [M_W-1:0]   o_q, o_d;
  logic             err_q, err_d;

  logic [M_W:0]     rem_chain [R+1];
  logic [R-1:0]     qbits;
  logic             zero_mod;
  logic             last_step;

  assign zero_mod  = (mod_q == '0);
  assign last_step = (state_q == RUN) && (cnt_q == '0);

  // R chained steps per cycle, consuming the top R bits of the shift register.
  assign rem_chain[0] = rem_q;
  for (genvar i = 0; i < int'(R); i++) begin : g_step
    mod_step #(.M_W(M_W)) u_step (
      .rem_i  (rem_chain[i]),
      .bit_i  (sh_q[NR-1-i]),
      .m_i    (mod_q),
      .rem_c  (rem_chain[i+1]),
      .qbit_c (qbits[R-1-i])
    );
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)     state_d = RUN;
      RUN:     if (cnt_q == '0)  state_d = HOLD;
      HOLD:    if (out_ready)    state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    m_ready   = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE:    begin m_ready = 1'b1; in_ready = 1'b1; end
      HOLD:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values: modulus/operand capture in IDLE, shifting and result latch in RUN.
  always_comb begin
    mod_d = mod_q;
    sh_d  = sh_q;
    rem_d = rem_q;
    cnt_d = cnt_q;
    o_d   = o_q;
    err_d = err_q;
    if (state_q == IDLE) begin
      if (m_valid) mod_d = m_data;
      if (in_valid) begin
        sh_d  = NR'(x);
        rem_d = '0;
        cnt_d = CNT_W'(N - 1);
      end
    end
    if (state_q == RUN) begin
      sh_d  = sh_q << R;
      rem_d = rem_chain[R];
      cnt_d = cnt_q - CNT_W'(1);
      if (last_step) begin
        o_d   = zero_mod ? '0 : rem_chain[R][M_W-1:0];
        err_d = zero_mod;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mod_q <= DEFAULT_MOD;
      sh_q  <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      o_q   <= '0;
      err_q <= 1'b0;
    end else begin
      mod_q <= mod_d;
      sh_q  <= sh_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
      o_q   <= o_d;
      err_q <= err_d;
    end
  end

  assign o   = o_q;
  assign err = err_q;

`ifdef MODRED_QUOT_EN
  logic [IN_W-1:0] qsh_q, qsh_d;
  logic [IN_W-1:0] quot_q, quot_d;

  // Quotient bits shift in LSB-side; the zero-extension bits fall off the top.
  always_comb begin
    qsh_d  = qsh_q;
    quot_d = quot_q;
    if (state_q == IDLE && in_valid) qsh_d = '0;
    if (state_q == RUN) begin
      qsh_d = IN_W'({qsh_q, qbits});
      if (last_step) quot_d = zero_mod ? '1 : IN_W'({qsh_q, qbits});
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      qsh_q  <= '0;
      quot_q <= '0;
    end else begin
      qsh_q  <= qsh_d;
      quot_q <= quot_d;
    end
  end

  assign quot = quot_q;
`else
  // Quotient bits have no consumer without the quotient register.
  logic unused_qbits;
  assign unused_qbits = ^qbits;
`endif

endmodule

// File: tb/tb_mod_reduce_seq.sv
// Self-checking bench for mod_reduce_seq (IN_W=16, M_W=8, R=4, DEFAULT_MOD=251).
module tb_mod_reduce_seq;

  localparam int IN_W = 16;
  localparam int M_W  = 8;
  localparam int R    = 4;
  localparam int N    = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            m_valid;
  logic [M_W-1:0]  m_data;
  logic            m_ready;
  logic            in_valid;
  logic [IN_W-1:0] x;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready;
  logic [M_W-1:0]  o;
  logic            err;
`ifdef MODRED_QUOT_EN
  logic [IN_W-1:0] quot;
`endif

  mod_reduce_seq #(
    .IN_W(IN_W), .M_W(M_W), .R(R), .DEFAULT_MOD(8'd251)
  ) dut (
    .clk(clk), .reset(reset),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .in_valid(in_valid), .x(x), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .o(o), .err(err)
`ifdef MODRED_QUOT_EN
    , .quot(quot)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer division.
  typedef struct {
    int o;
    int err;
    int q;
    int t0;
  } exp_t;

  function automatic exp_t ref_model(input int xv, input int mv, input int t0);
    exp_t e;
    e.t0 = t0;
    if (mv == 0) begin
      e.o = 0; e.err = 1; e.q = 16'hFFFF;
    end else begin
      e.o = xv % mv; e.err = 0; e.q = xv / mv;
    end
    return e;
  endfunction

  exp_t q_exp[$];
  int   model_mod = 251;
  bit   seen_valid = 0;
  bit   expect_idle = 0;
  int   retired = 0;
  int   last_o, last_err, last_q;

  // Compare process: sampled mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      q_exp.delete();
      model_mod   = 251;
      seen_valid  = 0;
      expect_idle = 0;
    end else begin
      if (expect_idle) begin
        check("in_ready_after_retire", in_ready, 1);
        check("out_valid_after_retire", out_valid, 0);
        expect_idle = 0;
      end
      if (out_valid) begin
        if (q_exp.size() == 0) begin
          check("spurious_out_valid", out_valid, 0);
        end else begin
          if (!seen_valid) begin
            check("latency", cyc - q_exp[0].t0, N);
            seen_valid = 1;
          end
          check("o", o, q_exp[0].o);
          check("err", err, q_exp[0].err);
`ifdef MODRED_QUOT_EN
          check("quot", quot, q_exp[0].q);
`endif
          check("in_ready_in_hold", in_ready, 0);
          check("m_ready_in_hold", m_ready, 0);
          if (out_ready) begin
            last_o   = o;
            last_err = err;
`ifdef MODRED_QUOT_EN
            last_q   = quot;
`endif
            void'(q_exp.pop_front());
            retired++;
            seen_valid  = 0;
            expect_idle = 1;
          end
        end
      end else if (q_exp.size() > 0) begin
        check("in_ready_in_run", in_ready, 0);
        if (cyc - q_exp[0].t0 > N) check("out_valid_late", out_valid, 1);
      end
      if (in_ready) begin
        if (m_valid) model_mod = int'(m_data);
        if (in_valid) q_exp.push_back(ref_model(int'(x), model_mod, cyc + 1));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!in_ready && k < 300) begin step(); k++; end
    if (!in_ready) check("in_ready_timeout", in_ready, 1);
  endtask

  task automatic load_mod(input logic [M_W-1:0] mv);
    wait_ready();
    m_valid = 1'b1; m_data = mv;
    step();
    m_valid = 1'b0;
  endtask

  task automatic send(input logic [IN_W-1:0] xv, input bit ld, input logic [M_W-1:0] mv);
    wait_ready();
    in_valid = 1'b1; x = xv; m_valid = ld; m_data = mv;
    step();
    in_valid = 1'b0; m_valid = 1'b0;
  endtask

  task automatic wait_retire(input int target, input bit rnd);
    int k = 0;
    while (retired < target && k < 300) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      step();
      k++;
    end
    out_ready = 1'b1;
    if (retired < target) check("retire_timeout", retired, target);
  endtask

  task automatic run_op(input logic [IN_W-1:0] xv, input bit ld, input logic [M_W-1:0] mv,
                        input bit rnd);
    int tgt;
    tgt = retired + 1;
    send(xv, ld, mv);
    wait_retire(tgt, rnd);
  endtask

  initial begin
    reset = 1'b0; m_valid = 1'b0; m_data = '0; in_valid = 1'b0; x = '0; out_ready = 1'b1;
    #2 reset = 1'b1;
    step(); step();
    check("rst_out_valid", out_valid, 0);
    check("rst_o", o, 0);
    check("rst_err", err, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_m_ready", m_ready, 1);
    reset = 1'b0;
    step();

    // Directed cases with literal expectations.
    run_op(16'hFFFF, 0, 0, 0);
    check("ffff_o", last_o, 24);
    check("ffff_err", last_err, 0);
`ifdef MODRED_QUOT_EN
    check("ffff_quot", last_q, 261);
`endif
    run_op(16'd250, 0, 0, 0); check("x250_o", last_o, 250);
    run_op(16'd251, 0, 0, 0); check("x251_o", last_o, 0);
    run_op(16'd0,   0, 0, 0); check("x0_o",   last_o, 0);
    run_op(16'd100, 1, 8'd7, 0); check("m7_same_cycle_o", last_o, 2);
    run_op(16'd100, 0, 0, 0);    check("m7_next_op_o",    last_o, 2);

    load_mod(8'd0);
    run_op(16'd1234, 0, 0, 0);
    check("m0_o", last_o, 0);
    check("m0_err", last_err, 1);
`ifdef MODRED_QUOT_EN
    check("m0_quot", last_q, 16'hFFFF);
`endif
    load_mod(8'd251);

    // Backpressure: result held for 5 cycles, then retires.
    begin
      int k = 0;
      out_ready = 1'b0;
      send(16'hFFFF, 0, 0);
      while (!out_valid && k < 50) begin step(); k++; end
      check("bp_out_valid", out_valid, 1);
      for (int i = 0; i < 5; i++) begin
        step();
        check("bp_o_stable", o, 24);
        check("bp_in_ready_low", in_ready, 0);
        check("bp_out_valid_held", out_valid, 1);
      end
      out_ready = 1'b1;
      step();
      check("bp_in_ready_back", in_ready, 1);
      check("bp_out_valid_drop", out_valid, 0);
    end

    // Reset two cycles into RUN, with a non-default modulus loaded.
    send(16'hFFFF, 1, 8'd7);
    step(); step();
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_o", o, 0);
    check("mid_rst_err", err, 0);
`ifdef MODRED_QUOT_EN
    check("mid_rst_quot", quot, 0);
`endif
    step(); step();
    reset = 1'b0;
    step();
    check("post_rst_in_ready", in_ready, 1);
    run_op(16'hFFFF, 0, 0, 0);
    check("post_rst_default_mod_o", last_o, 24);

    // Randomized operands, modulus loads and backpressure against the model.
    for (int i = 0; i < 60; i++) begin
      logic [IN_W-1:0] rx;
      logic [M_W-1:0]  rm;
      bit              ld;
      rx = IN_W'($urandom);
      ld = ($urandom_range(0, 3) == 0);
      rm = ($urandom_range(0, 19) == 0) ? 8'd0 : M_W'($urandom_range(1, 255));
      if (i == 59) begin ld = 1'b1; rm = 8'd1; end
      run_op(rx, ld, rm, 1);
    end

    step(); step();
    check("queue_drained", q_exp.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mod_reduce_seq.md
# mod_reduce_seq

Parametrised sequential modular reducer: computes o = x mod m for an IN_W-bit operand and a runtime-loadable M_W-bit modulus, retiring R operand bits per clock. It supersedes the fixed 300-bit-to-256-bit reducer in the arithmetic datapath and sits between the wide multiplier output and the field-element register file. It adds valid/ready handshakes, a loadable modulus and an error flag.

## Interface
- IN_W, 300: operand width in bits.
- M_W, 256: modulus and result width in bits.
- R, 4: operand bits consumed per cycle (1..8).
- DEFAULT_MOD, 2^256 - 2^32 - 977: modulus value after reset (M_W bits).
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- m_valid  in  1  modulus load request.
- m_data  in  M_W  new modulus.
- m_ready  out  1  modulus load accepted this cycle; equals the IDLE state.
- in_valid  in  1  operand valid.
- x  in  IN_W  operand.
- in_ready  out  1  operand accepted this cycle; equals the IDLE state.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed.
- o  out  M_W  remainder x mod m.
- err  out  1  modulus was zero for this result.
- quot  out  IN_W  quotient floor(x/m); only present with MODRED_QUOT_EN.

## Operation
- States: IDLE, RUN, HOLD.
- IDLE: m_ready=1, in_ready=1.
  - m_valid loads m_data into the modulus register.
  - in_valid captures x into the shift register, clears rem, loads the step counter with N-1, and moves to RUN. N = ceil(IN_W/R).
  - If m_valid and in_valid are both high in the same cycle, the new modulus applies to that operand.
- RUN: each cycle performs R serial steps, MSB first:
  - rem = {rem, next x bit}.
  - If rem >= m, then rem = rem - m and the quotient bit is 1; otherwise the quotient bit is 0.
  - When IN_W is not a multiple of R, the operand is zero-extended at the MSB end to N*R bits.
  - After the step at counter 0, move to HOLD.
- Arithmetic widths:
  - rem is M_W+1 bits internally, and the invariant rem < m holds between steps.
  - One conditional subtract per step is sufficient.
  - o is rem[M_W-1:0].
- Zero modulus: the datapath runs normally but o is forced to 0 and err to 1, and quot is forced to all ones.
- HOLD: out_valid=1, and o, err and quot are stable. When out_ready is high, move to IDLE.
- Input and modulus requests outside IDLE are ignored; the requester must hold valid.
- Reset at any time, including during RUN:
  - state goes to IDLE and the operation is discarded;
  - modulus returns to DEFAULT_MOD;
  - out_valid=0, o=0, err=0, quot=0.

## Timing
- Acceptance edge is t0. out_valid rises at t0+N; for the default parameters N=75.
- With out_ready already high, in_ready returns at t0+N+1. Peak throughput is one result per N+1 cycles.
- out_ready is sampled only in HOLD. The result holds indefinitely under backpressure.
- A modulus load at edge t takes effect for any operand accepted at edge t or later.
- There are no combinational paths from inputs to outputs; every output is registered or decoded from state.

## Configuration
- MODRED_QUOT_EN defined: the quot port and quotient shift register exist, and the quotient bits fill quot MSB first.
- Not defined: the port and register are absent. Remainder behaviour and timing are identical.

## Structure
- Package mod_pkg holds:
  - the state enum (IDLE/RUN/HOLD);
  - the default modulus constant;
  - a function for N = ceil(IN_W/R).
- Sub-module mod_step: one combinational shift/compare/subtract step of M_W+1 bits, instantiated R times in a generate loop.
- The top module owns the FSM, counter, handshake and modulus register.

## Test plan
All cases use IN_W=16, M_W=8, R=4, DEFAULT_MOD=251, so N=4.
- x=0xFFFF, with out_ready held high: out_valid rises 4 cycles after acceptance, o=24 (0x18), err=0, quot=261 (0x105).
- Boundaries:
  - x=250 gives o=250.
  - x=251 gives o=0.
  - x=0 gives o=0.
- Modulus handling:
  - m_valid with m_data=7 in the same cycle as x=100 gives o=2.
  - The next operand, x=100, still gives o=2.
- m_data=0 then x=1234: o=0, err=1, quot=0xFFFF.
- Backpressure: hold out_ready low for 5 cycles after out_valid. o stays stable and in_ready stays 0. The result retires on the first out_ready cycle, and in_ready=1 on the next cycle.
- Reset mid-operation: assert reset 2 cycles into RUN. All outputs go to 0 immediately, in_ready=1 after release, and the modulus is back to 251 (x=0xFFFF gives 24).
